// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback request bus plus register-file write port.
//   req_valid/req_addr/req_data : per-source push request (packed, source i in slice i)
//   req_ready/pending           : per-source FIFO can accept / is non-empty
//   reg_write/write_register/write_data : registered write toward the register file
//   master = writeback sources side, slave = arbiter side
interface regfile_write_arbiter_if #(
    parameter int dataWidth    = 64,
    parameter int addressWidth = 5,
    parameter int NUM_REQ      = 3
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*addressWidth-1:0] req_addr;
    logic [NUM_REQ*dataWidth-1:0]    req_data;
    logic [NUM_REQ-1:0]              pending;
    logic                            reg_write;
    logic [addressWidth-1:0]         write_register;
    logic [dataWidth-1:0]            write_data;
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, pending, reg_write, write_register, write_data
    );
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, pending, reg_write, write_register, write_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port among NUM_REQ 2-deep FIFOs.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : req_valid/req_ready/req_addr/req_data/pending per source,
//                  reg_write/write_register/write_data registered write stage
//   Optional macro REGWR_ZERO_DROP_EN: entries addressed to 31 are popped but not written.
module regfile_write_arbiter #(
    parameter int dataWidth    = 64,
    parameter int addressWidth = 5,
    parameter int NUM_REQ      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    logic [addressWidth-1:0] addr_mem_q [NUM_REQ][2];
    logic [dataWidth-1:0]    data_mem_q [NUM_REQ][2];
    logic [1:0]              cnt_q [NUM_REQ];
    logic [1:0]              cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [NUM_REQ-1:0]      push, pop, ready;
    logic [PW-1:0]           rr_q, rr_d, gnt_idx;
    logic                    gnt_vld, drop;
    logic [addressWidth-1:0] head_addr;
    logic [dataWidth-1:0]    head_data;
    logic                    we_q, we_d;
    logic [addressWidth-1:0] wreg_q, wreg_d;
    logic [dataWidth-1:0]    wdata_q, wdata_d;
    function automatic int wrap(input int v);
        return v >= NUM_REQ ? v - NUM_REQ : v;
    endfunction
    // Scan from rr_q upward; first non-empty FIFO wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_vld && cnt_q[wrap(int'(rr_q) + k)] != 2'd0) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(wrap(int'(rr_q) + k));
            end
        end
    end
    assign head_addr = addr_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
    assign head_data = data_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
`ifdef REGWR_ZERO_DROP_EN
    assign drop = head_addr == addressWidth'(31);
`else
    assign drop = 1'b0;
`endif
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
        // Ready is from the registered count only, so a full FIFO stays closed even while popping.
        assign ready[g]       = !reset && cnt_q[g] != 2'd2;
        assign push[g]        = bus.req_valid[g] && ready[g];
        assign pop[g]         = gnt_vld && gnt_idx == PW'(g);
        assign bus.pending[g] = cnt_q[g] != 2'd0;
    end
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i] + 2'(push[i]) - 2'(pop[i]);
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        rr_d     = !gnt_vld ? rr_q : gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + PW'(1);
        we_d     = gnt_vld && !drop;
        wreg_d   = we_d ? head_addr : wreg_q;
        wdata_d  = we_d ? head_data : wdata_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_q     <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_q     <= rr_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end
    // Storage needs no reset: push is already blocked while reset is high.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                addr_mem_q[i][wr_ptr_q[i]] <= bus.req_addr[i*addressWidth +: addressWidth];
                data_mem_q[i][wr_ptr_q[i]] <= bus.req_data[i*dataWidth +: dataWidth];
            end
        end
    end
    assign bus.req_ready      = ready;
    assign bus.reg_write      = we_q;
    assign bus.write_register = wreg_q;
    assign bus.write_data     = wdata_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: table-driven and directed checks of regfile_write_arbiter.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    regfile_write_arbiter_if #(.dataWidth(64), .addressWidth(5), .NUM_REQ(3)) bus();
    regfile_write_arbiter #(.dataWidth(64), .addressWidth(5), .NUM_REQ(3)) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit       rst;
        bit [2:0] v;
        bit [4:0] a0, a1, a2;
        bit       we;
        bit [4:0] wr;
        int       es;
        bit [2:0] rdy;
        bit [2:0] pd;
    } row_t;
    row_t tbl[24];
    logic [9:0] log_q[$];
    logic [4:0] s0_q[$];
    logic [4:0] s1_q[$];
    function automatic logic [63:0] dfun(input int src, input logic [4:0] a);
        return (64'(src) << 56) | 64'(a);
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    task automatic drive(input int s, input bit v, input logic [4:0] a, input logic [63:0] d);
        bus.req_valid[s]       = v;
        bus.req_addr[s*5 +: 5]  = a;
        bus.req_data[s*64 +: 64] = d;
    endtask
    task automatic idle();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 64'd0);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.reg_write) log_q.push_back({bus.write_data[57:56], bus.write_register, 3'b0});
    endtask
    initial begin
        tbl[0]  = '{1, 3'b111, 9, 9, 9, 0, 0, 0, 3'b000, 3'b000};
        tbl[1]  = '{1, 3'b111, 9, 9, 9, 0, 0, 0, 3'b000, 3'b000};
        tbl[2]  = '{1, 3'b111, 9, 9, 9, 0, 0, 0, 3'b000, 3'b000};
        tbl[3]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000};
        tbl[4]  = '{0, 3'b001, 5, 0, 0, 0, 0, 0, 3'b111, 3'b001};
        tbl[5]  = '{0, 3'b000, 0, 0, 0, 1, 5, 0, 3'b111, 3'b000};
        tbl[6]  = '{0, 3'b100, 0, 0, 4, 0, 5, 0, 3'b111, 3'b100};
        tbl[7]  = '{0, 3'b000, 0, 0, 0, 1, 4, 2, 3'b111, 3'b000};
        tbl[8]  = '{0, 3'b111, 1, 2, 3, 0, 4, 2, 3'b111, 3'b111};
        tbl[9]  = '{0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b111, 3'b110};
        tbl[10] = '{0, 3'b000, 0, 0, 0, 1, 2, 1, 3'b111, 3'b100};
        tbl[11] = '{0, 3'b000, 0, 0, 0, 1, 3, 2, 3'b111, 3'b000};
        tbl[12] = '{0, 3'b000, 0, 0, 0, 0, 3, 2, 3'b111, 3'b000};
        tbl[13] = '{0, 3'b001, 6, 0, 0, 0, 3, 2, 3'b111, 3'b001};
        tbl[14] = '{0, 3'b000, 0, 0, 0, 1, 6, 0, 3'b111, 3'b000};
        tbl[15] = '{0, 3'b111, 1, 2, 3, 0, 6, 0, 3'b111, 3'b111};
        tbl[16] = '{0, 3'b000, 0, 0, 0, 1, 2, 1, 3'b111, 3'b101};
        tbl[17] = '{0, 3'b000, 0, 0, 0, 1, 3, 2, 3'b111, 3'b001};
        tbl[18] = '{0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b111, 3'b000};
        tbl[19] = '{0, 3'b000, 0, 0, 0, 0, 1, 0, 3'b111, 3'b000};
        tbl[20] = '{0, 3'b001, 8, 0, 0, 0, 1, 0, 3'b111, 3'b001};
        tbl[21] = '{0, 3'b001, 9, 0, 0, 1, 8, 0, 3'b111, 3'b001};
        tbl[22] = '{0, 3'b000, 0, 0, 0, 1, 9, 0, 3'b111, 3'b000};
        tbl[23] = '{0, 3'b000, 0, 0, 0, 0, 9, 0, 3'b111, 3'b000};
        idle();
        for (int r = 0; r < 24; r++) begin
            rst = tbl[r].rst;
            drive(0, tbl[r].v[0], tbl[r].a0, dfun(0, tbl[r].a0));
            drive(1, tbl[r].v[1], tbl[r].a1, dfun(1, tbl[r].a1));
            drive(2, tbl[r].v[2], tbl[r].a2, dfun(2, tbl[r].a2));
            tick();
            chk($sformatf("row%0d reg_write", r), 64'(bus.reg_write), 64'(tbl[r].we));
            chk($sformatf("row%0d write_register", r), 64'(bus.write_register), 64'(tbl[r].wr));
            chk($sformatf("row%0d write_data", r), bus.write_data, dfun(tbl[r].es, tbl[r].wr));
            chk($sformatf("row%0d req_ready", r), 64'(bus.req_ready), 64'(tbl[r].rdy));
            chk($sformatf("row%0d pending", r), 64'(bus.pending), 64'(tbl[r].pd));
        end
        // single write: commit visible exactly one cycle after the push edge
        drive(0, 1'b1, 5'd5, 64'hDEAD);
        tick();
        idle();
        chk("single push edge reg_write", 64'(bus.reg_write), 64'd0);
        tick();
        chk("single reg_write", 64'(bus.reg_write), 64'd1);
        chk("single write_register", 64'(bus.write_register), 64'd5);
        chk("single write_data", bus.write_data, 64'hDEAD);
        tick();
        chk("single after reg_write", 64'(bus.reg_write), 64'd0);
        // steer rr_ptr to 0 through a lone src2 write
        drive(2, 1'b1, 5'd4, dfun(2, 5'd4));
        tick();
        idle();
        tick();
        tick();
        // backpressure on src1 while src0 keeps pushing
        log_q.delete();
        drive(0, 1'b1, 5'd20, dfun(0, 5'd20));
        drive(1, 1'b1, 5'd11, dfun(1, 5'd11));
        tick();
        chk("bp ready after push1", 64'(bus.req_ready), 64'b111);
        drive(0, 1'b1, 5'd21, dfun(0, 5'd21));
        drive(1, 1'b1, 5'd12, dfun(1, 5'd12));
        tick();
        chk("bp ready1 full", 64'(bus.req_ready[1]), 64'd0);
        chk("bp ready0 open", 64'(bus.req_ready[0]), 64'd1);
        drive(0, 1'b1, 5'd22, dfun(0, 5'd22));
        drive(1, 1'b1, 5'd13, dfun(1, 5'd13));
        tick();
        chk("bp ready1 after pop", 64'(bus.req_ready[1]), 64'd1);
        chk("bp ready0 full", 64'(bus.req_ready[0]), 64'd0);
        chk("bp first src1 commit", 64'(bus.write_register), 64'd11);
        drive(0, 1'b0, 5'd0, 64'd0);
        tick();
        idle();
        for (int c = 0; c < 6; c++) tick();
        chk("bp drained pending", 64'(bus.pending), 64'd0);
        foreach (log_q[n]) begin
            if (log_q[n][9:8] == 2'd0) s0_q.push_back(log_q[n][7:3]);
            if (log_q[n][9:8] == 2'd1) s1_q.push_back(log_q[n][7:3]);
        end
        chk("bp src1 count", 64'(s1_q.size()), 64'd3);
        chk("bp src0 count", 64'(s0_q.size()), 64'd3);
        if (s1_q.size() == 3) begin
            chk("bp src1 order0", 64'(s1_q[0]), 64'd11);
            chk("bp src1 order1", 64'(s1_q[1]), 64'd12);
            chk("bp src1 order2", 64'(s1_q[2]), 64'd13);
        end
        if (s0_q.size() == 3) begin
            chk("bp src0 order0", 64'(s0_q[0]), 64'd20);
            chk("bp src0 order1", 64'(s0_q[1]), 64'd21);
            chk("bp src0 order2", 64'(s0_q[2]), 64'd22);
        end
        // reset mid-traffic
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 3; s++) drive(s, 1'b1, 5'(10 + s + 3*c), dfun(s, 5'(10 + s + 3*c)));
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        chk("midrst reg_write", 64'(bus.reg_write), 64'd0);
        chk("midrst pending", 64'(bus.pending), 64'd0);
        chk("midrst ready", 64'(bus.req_ready), 64'd0);
        chk("midrst write_register", 64'(bus.write_register), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("postrst%0d reg_write", c), 64'(bus.reg_write), 64'd0);
            chk($sformatf("postrst%0d pending", c), 64'(bus.pending), 64'd0);
        end
        chk("postrst ready", 64'(bus.req_ready), 64'b111);
        // address 31 handling on src2
        drive(2, 1'b1, 5'd31, dfun(2, 5'd31));
        tick();
        drive(2, 1'b1, 5'd7, dfun(2, 5'd7));
        tick();
        idle();
`ifdef REGWR_ZERO_DROP_EN
        chk("xzr dropped reg_write", 64'(bus.reg_write), 64'd0);
        chk("xzr dropped write_register", 64'(bus.write_register), 64'd0);
`else
        chk("xzr reg_write", 64'(bus.reg_write), 64'd1);
        chk("xzr write_register", 64'(bus.write_register), 64'd31);
        chk("xzr write_data", bus.write_data, dfun(2, 5'd31));
`endif
        tick();
        chk("after xzr reg_write", 64'(bus.reg_write), 64'd1);
        chk("after xzr write_register", 64'(bus.write_register), 64'd7);
        chk("after xzr write_data", bus.write_data, dfun(2, 5'd7));
        tick();
        chk("xzr idle reg_write", 64'(bus.reg_write), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
